// File: rtl/hangman_controller.sv
// Moore FSM sequencing the blind-hangman datapath: init, word pick, guess capture, hit/miss, win/lose.
// Latency: outputs decoded from state only; a guess takes 5 cycles from WAIT_CHAR back to WAIT_CHAR.
// Backpressure: none; char_valid is dropped outside WAIT_CHAR, new_game is dropped outside DONE.
module hangman_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] input_char_eq_word,
    input  logic       guessed_letters_is_done,
    input  logic       tries_is_zero,
    input  logic       char_valid,
    input  logic       new_game,
    output logic       s_tries,
    output logic       en_tries,
    output logic [2:0] s_guessed_letters,
    output logic [2:0] en_guessed_letters,
    output logic       en_word_index,
    output logic       en_input_char,
    output logic       s_win,
    output logic       en_win,
    output logic       s_lose,
    output logic       en_lose
);

    // State encoding; codes 12..15 are unreachable and fall back to INIT
    localparam logic [3:0] ST_INIT       = 4'd0;
    localparam logic [3:0] ST_GEN_WORD   = 4'd1;
    localparam logic [3:0] ST_WAIT_CHAR  = 4'd2;
    localparam logic [3:0] ST_LOAD_CHAR  = 4'd3;
    localparam logic [3:0] ST_COMPARE    = 4'd4;
    localparam logic [3:0] ST_HIT        = 4'd5;
    localparam logic [3:0] ST_MISS       = 4'd6;
    localparam logic [3:0] ST_CHECK_WIN  = 4'd7;
    localparam logic [3:0] ST_CHECK_LOSE = 4'd8;
    localparam logic [3:0] ST_WIN        = 4'd9;
    localparam logic [3:0] ST_LOSE       = 4'd10;
    localparam logic [3:0] ST_DONE       = 4'd11;

    // Guessed-mask operation codes
    localparam logic [2:0] GL_CLEAR = 3'd0;
    localparam logic [2:0] GL_OR    = 3'd1;
    localparam logic [2:0] GL_WRITE = 3'b001;
    localparam logic [2:0] GL_HOLD  = 3'b000;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_hit;

    // Any matching position makes the latched letter a hit, repeats included
    assign w_hit = |input_char_eq_word;

    // State register; reset takes priority over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection from current state and datapath status
    always_comb begin
        w_next_state = ST_INIT;
        case (r_state)
            ST_INIT:       w_next_state = ST_GEN_WORD;
            ST_GEN_WORD:   w_next_state = ST_WAIT_CHAR;
            ST_WAIT_CHAR:  w_next_state = char_valid ? ST_LOAD_CHAR : ST_WAIT_CHAR;
            ST_LOAD_CHAR:  w_next_state = ST_COMPARE;
            ST_COMPARE:    w_next_state = w_hit ? ST_HIT : ST_MISS;
            ST_HIT:        w_next_state = ST_CHECK_WIN;
            ST_MISS:       w_next_state = ST_CHECK_LOSE;
            ST_CHECK_WIN:  w_next_state = guessed_letters_is_done ? ST_WIN : ST_WAIT_CHAR;
            ST_CHECK_LOSE: w_next_state = tries_is_zero ? ST_LOSE : ST_WAIT_CHAR;
            ST_WIN:        w_next_state = ST_DONE;
            ST_LOSE:       w_next_state = ST_DONE;
            ST_DONE:       w_next_state = new_game ? ST_INIT : ST_DONE;
            default:       w_next_state = ST_INIT;
        endcase
    end

    // Moore output decode: every strobe defaults low and is raised only in its own state
    always_comb begin
        s_tries            = 1'b0;
        en_tries           = 1'b0;
        s_guessed_letters  = GL_CLEAR;
        en_guessed_letters = GL_HOLD;
        en_word_index      = 1'b0;
        en_input_char      = 1'b0;
        s_win              = 1'b0;
        en_win             = 1'b0;
        s_lose             = 1'b0;
        en_lose            = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Load tries with 7, clear the mask, and clear both result flags
                s_tries            = 1'b1;
                en_tries           = 1'b1;
                s_guessed_letters  = GL_CLEAR;
                en_guessed_letters = GL_WRITE;
                en_win             = 1'b1;
                en_lose            = 1'b1;
            end
            ST_GEN_WORD: begin
                en_word_index = 1'b1;
            end
            ST_LOAD_CHAR: begin
                en_input_char = 1'b1;
            end
            ST_HIT: begin
                s_guessed_letters  = GL_OR;
                en_guessed_letters = GL_WRITE;
            end
            ST_MISS: begin
                // s_tries stays 0 so the tries mux selects the decrement path
                en_tries = 1'b1;
            end
            ST_WIN: begin
                s_win  = 1'b1;
                en_win = 1'b1;
            end
            ST_LOSE: begin
                s_lose  = 1'b1;
                en_lose = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_hangman_controller.sv
// Randomised bench for hangman_controller: a game-level model plays hangman and schedules
// the expected per-cycle strobe vector for each reset, guess and restart it issues.
// Datapath status inputs are produced by the bench's own game model, never by the DUT.
module tb_hangman_controller;

    logic       clk;
    logic       reset;
    logic [4:0] input_char_eq_word;
    logic       guessed_letters_is_done;
    logic       tries_is_zero;
    logic       char_valid;
    logic       new_game;
    logic       s_tries;
    logic       en_tries;
    logic [2:0] s_guessed_letters;
    logic [2:0] en_guessed_letters;
    logic       en_word_index;
    logic       en_input_char;
    logic       s_win;
    logic       en_win;
    logic       s_lose;
    logic       en_lose;

    hangman_controller dut (
        .clk                     (clk),
        .reset                   (reset),
        .input_char_eq_word      (input_char_eq_word),
        .guessed_letters_is_done (guessed_letters_is_done),
        .tries_is_zero           (tries_is_zero),
        .char_valid              (char_valid),
        .new_game                (new_game),
        .s_tries                 (s_tries),
        .en_tries                (en_tries),
        .s_guessed_letters       (s_guessed_letters),
        .en_guessed_letters      (en_guessed_letters),
        .en_word_index           (en_word_index),
        .en_input_char           (en_input_char),
        .s_win                   (s_win),
        .en_win                  (en_win),
        .s_lose                  (s_lose),
        .en_lose                 (en_lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout:
    // {s_tries, en_tries, s_guessed[2:0], en_guessed[2:0], en_word_index, en_input_char, s_win, en_win, s_lose, en_lose}
    localparam logic [13:0] V_ZERO = 14'b0_0_000_000_0_0_0_0_0_0;
    localparam logic [13:0] V_INIT = 14'b1_1_000_001_0_0_0_1_0_1;
    localparam logic [13:0] V_GEN  = 14'b0_0_000_000_1_0_0_0_0_0;
    localparam logic [13:0] V_LOAD = 14'b0_0_000_000_0_1_0_0_0_0;
    localparam logic [13:0] V_HIT  = 14'b0_0_001_001_0_0_0_0_0_0;
    localparam logic [13:0] V_MISS = 14'b0_1_000_000_0_0_0_0_0_0;
    localparam logic [13:0] V_WIN  = 14'b0_0_000_000_0_0_1_1_0_0;
    localparam logic [13:0] V_LOSE = 14'b0_0_000_000_0_0_0_0_1_1;

    int          vectors;
    int          miscompares;
    int          cyc;

    // Game model: secret word, letters found so far, remaining tries, and whether a game is live
    int          word [5];
    logic [4:0]  found;
    int          tries;
    bit          game_over;
    logic [13:0] exp_q [$];
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    int          wins;
    int          losses;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic start_game();
        for (int i = 0; i < 5; i++) word[i] = $urandom_range(0, 9);
        found     = 5'b0;
        tries     = 7;
        game_over = 1'b0;
        input_char_eq_word      = 5'b0;
        guessed_letters_is_done = 1'b0;
        tries_is_zero           = 1'b0;
    endtask

    // Play one letter against the model and queue the strobes the controller must emit
    task automatic play_guess();
        int         letter;
        logic [4:0] m;
        letter = $urandom_range(0, 9);
        m = 5'b0;
        for (int i = 0; i < 5; i++) if (word[i] == letter) m[i] = 1'b1;
        exp_q.push_back(V_LOAD);
        exp_q.push_back(V_ZERO);
        if (m != 5'b0) begin
            found = found | m;
            exp_q.push_back(V_HIT);
            exp_q.push_back(V_ZERO);
            if (found == 5'b11111) begin
                exp_q.push_back(V_WIN);
                exp_q.push_back(V_ZERO);
                game_over = 1'b1;
                wins++;
            end else begin
                exp_q.push_back(V_ZERO);
            end
        end else begin
            tries = tries - 1;
            exp_q.push_back(V_MISS);
            exp_q.push_back(V_ZERO);
            if (tries == 0) begin
                exp_q.push_back(V_LOSE);
                exp_q.push_back(V_ZERO);
                game_over = 1'b1;
                losses++;
            end else begin
                exp_q.push_back(V_ZERO);
            end
        end
        // Status held for the whole guess; the controller only samples it in COMPARE / CHECK_*
        input_char_eq_word      = m;
        guessed_letters_is_done = (found == 5'b11111);
        tries_is_zero           = (tries == 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wins        = 0;
        losses      = 0;
        reset       = 1'b1;
        char_valid  = 1'b0;
        new_game    = 1'b0;
        start_game();

        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // Stimulus: reset at start, continuous char_valid in the first phase, then random traffic
            if (cyc < 3) reset = 1'b1;
            else         reset = ($urandom_range(0, 99) < 2);
            if (cyc < 800) char_valid = 1'b1;
            else           char_valid = ($urandom_range(0, 99) < 40);
            new_game = ($urandom_range(0, 99) < 30);

            if (reset) begin
                exp_q.delete();
                exp_q.push_back(V_INIT);
                exp_q.push_back(V_GEN);
                exp_q.push_back(V_ZERO);
                start_game();
            end else if (exp_q.size() == 0) begin
                if (!game_over && char_valid) begin
                    play_guess();
                end else if (game_over && new_game) begin
                    exp_q.push_back(V_INIT);
                    exp_q.push_back(V_GEN);
                    exp_q.push_back(V_ZERO);
                    start_game();
                end
            end
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : V_ZERO;

            @(posedge clk);
            #1;
            obs_v = {s_tries, en_tries, s_guessed_letters, en_guessed_letters,
                     en_word_index, en_input_char, s_win, en_win, s_lose, en_lose};
            check(reset ? "reset_init" : "strobes", obs_v, exp_v);
        end

        $display("games won=%0d lost=%0d", wins, losses);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
